// File: rtl/spinner_bank.sv
// rtl/spinner_bank.sv - multi-channel spinner/paddle angle registers with acceleration, delta and preset
module spinner_bank #(
   parameter int CHANNELS   = 2,
   parameter int WIDTH      = 8,
   parameter int STEP       = 4,
   parameter int ACCEL_MAX  = 3,
   parameter int ACCEL_HOLD = 8,
   parameter int CLAMP      = 0,
   parameter int RESET_VAL  = 0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      strobe,
   input  logic [CHANNELS-1:0]       minus,
   input  logic [CHANNELS-1:0]       plus,
   input  logic [CHANNELS-1:0]       use_spinner,
   input  logic                      delta_valid,
   input  logic [2:0]                delta_ch,
   input  logic [7:0]                delta,
   input  logic                      preset_we,
   input  logic [2:0]                preset_ch,
   input  logic [WIDTH-1:0]          preset_value,
   output logic [CHANNELS*WIDTH-1:0] angle,
   output logic [CHANNELS-1:0]       moving
);

   // Signed intermediate wide enough for angle + accelerated step + delta
   localparam int SW = WIDTH + 10;
   localparam int HW = 8;
   localparam int LW = 4;
   localparam logic signed [SW-1:0] MAX_S = SW'((1 << WIDTH) - 1);

   logic                strobe_d;
   logic                tick;
   logic [CHANNELS-1:0] plus_d, minus_d, mode_d;
   logic [CHANNELS-1:0] last_valid, last_dir;
   logic [LW-1:0]       level_q [CHANNELS];
   logic [HW-1:0]       hold_q  [CHANNELS];
   logic [WIDTH-1:0]    ang_q   [CHANNELS];

   logic [CHANNELS-1:0] last_valid_n, last_dir_n, moving_n;
   logic [LW-1:0]       level_n [CHANNELS];
   logic [HW-1:0]       hold_n  [CHANNELS];
   logic [WIDTH-1:0]    ang_n   [CHANNELS];

   logic signed [SW-1:0] inc_v, step_v, sum_v;
   logic                 p_edge, m_edge;

   // Per-channel next angle and acceleration state
   always_comb begin
      tick         = strobe & ~strobe_d;
      inc_v        = '0;
      step_v       = '0;
      sum_v        = '0;
      p_edge       = 1'b0;
      m_edge       = 1'b0;
      last_valid_n = last_valid;
      last_dir_n   = last_dir;
      moving_n     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         inc_v      = '0;
         step_v     = SW'(STEP) << level_q[i];
         level_n[i] = level_q[i];
         hold_n[i]  = hold_q[i];
         if (use_spinner[i]) begin
            level_n[i]      = '0;
            hold_n[i]       = '0;
            last_valid_n[i] = 1'b0;
            p_edge          = plus[i] & ~plus_d[i];
            m_edge          = minus[i] & ~minus_d[i];
            if (p_edge && !m_edge)
               inc_v = SW'(1);
            else if (m_edge && !p_edge)
               inc_v = {SW{1'b1}};
         end else if (tick) begin
            if (plus[i] ^ minus[i]) begin
               last_valid_n[i] = 1'b1;
               last_dir_n[i]   = plus[i];
               if (last_valid[i] && (last_dir[i] != plus[i])) begin
                  // Reversal tick: stand still, restart acceleration
                  level_n[i] = '0;
                  hold_n[i]  = '0;
               end else begin
                  inc_v = plus[i] ? step_v : -step_v;
                  if (hold_q[i] == HW'(ACCEL_HOLD - 1)) begin
                     hold_n[i] = '0;
                     if (level_q[i] < LW'(ACCEL_MAX))
                        level_n[i] = level_q[i] + 1'b1;
                  end else begin
                     hold_n[i] = hold_q[i] + 1'b1;
                  end
               end
            end else begin
               level_n[i]      = '0;
               hold_n[i]       = '0;
               last_valid_n[i] = 1'b0;
            end
         end
         if (use_spinner[i] != mode_d[i]) begin
            level_n[i]      = '0;
            hold_n[i]       = '0;
            last_valid_n[i] = 1'b0;
         end
         if (delta_valid && (delta_ch == 3'(i)))
            inc_v = inc_v + {{(SW-8){delta[7]}}, delta};
         sum_v = $signed({10'b0, ang_q[i]}) + inc_v;
         if (CLAMP != 0) begin
            if (sum_v < 0)
               ang_n[i] = '0;
            else if (sum_v > MAX_S)
               ang_n[i] = '1;
            else
               ang_n[i] = sum_v[WIDTH-1:0];
         end else begin
            ang_n[i] = sum_v[WIDTH-1:0];
         end
         if (preset_we && (preset_ch == 3'(i))) begin
            ang_n[i]        = preset_value;
            level_n[i]      = '0;
            hold_n[i]       = '0;
            last_valid_n[i] = 1'b0;
         end
         moving_n[i] = (ang_n[i] != ang_q[i]);
      end
   end

   // State registers; history updates every cycle regardless of mode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strobe_d   <= 1'b0;
         plus_d     <= '0;
         minus_d    <= '0;
         mode_d     <= '0;
         last_valid <= '0;
         last_dir   <= '0;
         moving     <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            level_q[i] <= '0;
            hold_q[i]  <= '0;
            ang_q[i]   <= WIDTH'(RESET_VAL);
         end
      end else begin
         strobe_d   <= strobe;
         plus_d     <= plus;
         minus_d    <= minus;
         mode_d     <= use_spinner;
         last_valid <= last_valid_n;
         last_dir   <= last_dir_n;
         moving     <= moving_n;
         for (int i = 0; i < CHANNELS; i++) begin
            level_q[i] <= level_n[i];
            hold_q[i]  <= hold_n[i];
            ang_q[i]   <= ang_n[i];
         end
      end
   end

   // Pack channel angles onto the output bus
   always_comb begin
      angle = '0;
      for (int i = 0; i < CHANNELS; i++)
         angle[i*WIDTH +: WIDTH] = ang_q[i];
   end

endmodule

// File: tb/tb_spinner_bank.sv
// tb/tb_spinner_bank.sv - directed bench for spinner_bank (wrap and clamp instances)
module tb_spinner_bank;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        strobe;
   logic [1:0]  plus, minus, use_spinner;
   logic        delta_valid;
   logic [2:0]  delta_ch;
   logic [7:0]  delta;
   logic        preset_we;
   logic [2:0]  preset_ch;
   logic [7:0]  preset_value;
   logic [15:0] angle0;
   logic [1:0]  mv0;

   logic [1:0]  c_plus, c_minus, c_use;
   logic        c_dv;
   logic [2:0]  c_dch;
   logic [7:0]  c_delta;
   logic        c_pwe;
   logic [2:0]  c_pch;
   logic [7:0]  c_pval;
   logic [15:0] angle1;
   logic [1:0]  mv1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       dv;
      logic [2:0] dch;
      logic [7:0] dl;
      logic       pwe;
      logic [2:0] pch;
      logic [7:0] pv;
      int         e0;
      int         e1;
      logic [1:0] emv;
   } cvec_t;

   cvec_t cv [13];

   always #5 clk = ~clk;

   spinner_bank #(.CLAMP(0)) u_wrap (
      .clk(clk), .reset_n(reset_n), .strobe(strobe),
      .minus(minus), .plus(plus), .use_spinner(use_spinner),
      .delta_valid(delta_valid), .delta_ch(delta_ch), .delta(delta),
      .preset_we(preset_we), .preset_ch(preset_ch), .preset_value(preset_value),
      .angle(angle0), .moving(mv0)
   );

   spinner_bank #(.CLAMP(1)) u_clamp (
      .clk(clk), .reset_n(reset_n), .strobe(strobe),
      .minus(c_minus), .plus(c_plus), .use_spinner(c_use),
      .delta_valid(c_dv), .delta_ch(c_dch), .delta(c_delta),
      .preset_we(c_pwe), .preset_ch(c_pch), .preset_value(c_pval),
      .angle(angle1), .moving(mv1)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Angle after n consecutive held ticks from level 0 (STEP=4, ACCEL_HOLD=8, ACCEL_MAX=3)
   function automatic int acc_exp(input int n);
      if (n <= 8)       return 4 * n;
      else if (n <= 16) return 32 + 8 * (n - 8);
      else if (n <= 24) return 96 + 16 * (n - 16);
      else              return (224 + 32 * (n - 24)) % 256;
   endfunction

   task automatic tick_chk(input string name, input int exp_a0, input int exp_mv0);
      strobe = 1'b1;
      @(negedge clk);
      chk({name, "_angle"}, int'(angle0[7:0]), exp_a0);
      chk({name, "_moving"}, int'(mv0[0]), exp_mv0);
      strobe = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cv[0]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'd250, 250,   0, 2'b01};
      cv[1]  = '{1'b1, 3'd0, 8'd20, 1'b0, 3'd0, 8'd0,   255,   0, 2'b01};
      cv[2]  = '{1'b1, 3'd0, 8'h80, 1'b0, 3'd0, 8'd0,   127,   0, 2'b01};
      cv[3]  = '{1'b1, 3'd0, 8'h80, 1'b0, 3'd0, 8'd0,     0,   0, 2'b01};
      cv[4]  = '{1'b1, 3'd0, 8'h80, 1'b0, 3'd0, 8'd0,     0,   0, 2'b00};
      cv[5]  = '{1'b1, 3'd1, 8'hFD, 1'b0, 3'd0, 8'd0,     0,   0, 2'b00};
      cv[6]  = '{1'b1, 3'd1, 8'd100, 1'b0, 3'd0, 8'd0,    0, 100, 2'b10};
      cv[7]  = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd0, 8'd255, 255, 100, 2'b01};
      cv[8]  = '{1'b1, 3'd0, 8'd5,  1'b0, 3'd0, 8'd0,   255, 100, 2'b00};
      cv[9]  = '{1'b0, 3'd0, 8'd0,  1'b1, 3'd5, 8'd7,   255, 100, 2'b00};
      cv[10] = '{1'b1, 3'd3, 8'd9,  1'b0, 3'd0, 8'd0,   255, 100, 2'b00};
      cv[11] = '{1'b1, 3'd1, 8'd50, 1'b1, 3'd1, 8'h10,  255,  16, 2'b10};
      cv[12] = '{1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 8'd0,   255,  16, 2'b00};

      reset_n = 1'b0; strobe = 1'b0;
      plus = '0; minus = '0; use_spinner = '0;
      delta_valid = 1'b0; delta_ch = '0; delta = '0;
      preset_we = 1'b0; preset_ch = '0; preset_value = '0;
      c_plus = '0; c_minus = '0; c_use = '0;
      c_dv = 1'b0; c_dch = '0; c_delta = '0;
      c_pwe = 1'b0; c_pch = '0; c_pval = '0;
      repeat (3) @(negedge clk);
      chk("reset_wrap_angle", int'(angle0), 0);
      chk("reset_wrap_moving", int'(mv0), 0);
      chk("reset_clamp_angle", int'(angle1), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Held-button acceleration on ch0, wrapping at 256
      plus[0] = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         tick_chk($sformatf("accel_t%0d", n), acc_exp(n), 1);
         chk($sformatf("accel_idle%0d", n), int'(mv0[0]), 0);
      end

      // Asynchronous reset mid-acceleration
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_angle", int'(angle0), 0);
      chk("async_reset_moving", int'(mv0), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_moving", int'(mv0), 0);
      tick_chk("post_reset_tick", 4, 1);
      plus[0] = 1'b0;
      @(negedge clk);

      // Spinner mode on ch1
      use_spinner[1] = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         plus[1] = 1'b1;
         @(negedge clk);
         chk($sformatf("spin_plus%0d", k), int'(angle0[15:8]), k);
         chk($sformatf("spin_plus_mv%0d", k), int'(mv0[1]), 1);
         plus[1] = 1'b0;
         @(negedge clk);
      end
      for (int k = 1; k <= 7; k++) begin
         minus[1] = 1'b1;
         @(negedge clk);
         chk($sformatf("spin_minus%0d", k), int'(angle0[15:8]), (5 - k + 256) % 256);
         minus[1] = 1'b0;
         @(negedge clk);
      end
      plus[1] = 1'b1; minus[1] = 1'b1;
      @(negedge clk);
      chk("spin_both_angle", int'(angle0[15:8]), 254);
      chk("spin_both_moving", int'(mv0[1]), 0);
      tick_chk("spin_tick_ch0", 4, 0);
      chk("spin_tick_ignored", int'(angle0[15:8]), 254);
      plus[1] = 1'b0; minus[1] = 1'b0;
      @(negedge clk);

      // Tick step and delta summed in one update, then preset overrides both
      plus[0] = 1'b1;
      delta_valid = 1'b1; delta_ch = 3'd0; delta = 8'hFD;
      tick_chk("sum_tick_delta", 5, 1);
      delta_valid = 1'b1;
      preset_we = 1'b1; preset_ch = 3'd0; preset_value = 8'h80;
      strobe = 1'b1;
      @(negedge clk);
      chk("preset_override", int'(angle0[7:0]), 128);
      strobe = 1'b0; delta_valid = 1'b0; preset_we = 1'b0;
      @(negedge clk);

      // Reach level 2, then reverse direction
      for (int n = 1; n <= 17; n++)
         tick_chk($sformatf("rev_up%0d", n), (128 + acc_exp(n)) % 256, 1);
      plus[0] = 1'b0; minus[0] = 1'b1;
      tick_chk("rev_pause", 240, 0);
      tick_chk("rev_down1", 236, 1);
      tick_chk("rev_down2", 232, 1);

      // Mode toggles with plus held must not step
      minus[0] = 1'b0; plus[0] = 1'b1;
      repeat (2) @(negedge clk);
      use_spinner[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("toggle_on_angle%0d", k), int'(angle0[7:0]), 232);
         chk($sformatf("toggle_on_mv%0d", k), int'(mv0[0]), 0);
      end
      use_spinner[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("toggle_off_angle%0d", k), int'(angle0[7:0]), 232);
      end
      tick_chk("toggle_then_tick", 236, 1);
      plus[0] = 1'b0;

      // Saturating instance: delta and preset table
      for (int v = 0; v < 13; v++) begin
         c_dv = cv[v].dv; c_dch = cv[v].dch; c_delta = cv[v].dl;
         c_pwe = cv[v].pwe; c_pch = cv[v].pch; c_pval = cv[v].pv;
         @(negedge clk);
         chk($sformatf("clamp_v%0d_ch0", v), int'(angle1[7:0]), cv[v].e0);
         chk($sformatf("clamp_v%0d_ch1", v), int'(angle1[15:8]), cv[v].e1);
         chk($sformatf("clamp_v%0d_moving", v), int'(mv1), int'(cv[v].emv));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
